branch_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_sat_counter.sv | 23 ++
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared sizing helpers and saturating-counter constants for the branch predictor.
package bp_pkg;

  // Index bits select a BTB entry; the two byte-offset bits sit below them.
  function automatic int bp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int bp_tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  function automatic int CNT_MAX(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic int CNT_WEAK_TAKEN(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next value of a CNT_W-bit saturating up/down counter.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(CNT_MAX(CNT_W));

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != MAX_VAL) cnt_next = cnt + 1'b1;
    end else begin
      if (cnt != '0) cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor: combinational IF lookup, EX resolve/update.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcif,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_pc,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     lookup_num,
  output logic [31:0]     hit_num,
  output logic [31:0]     mispredict_num
);

  localparam int IDX_W = bp_idx_w(ENTRIES);
  localparam int TAG_W = bp_tag_w(PC_W, ENTRIES);
  localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(CNT_WEAK_TAKEN(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] cnt;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  // The prediction itself is not needed: the predicted PC alone decides a mispredict.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  btb_entry_t       if_ent;
  logic             if_hit;

  assign if_idx = pcif[IDX_W+1:2];
  assign if_tag = pcif[PC_W-1:IDX_W+2];
  assign if_ent = btb[if_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

  assign pred_taken   = !rst && if_hit && if_ent.cnt[CNT_W-1];
  assign pred_next_pc = pred_taken ? if_ent.target : pcif + PC_W'(4);

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       upd_ent;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_cnt_next;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
  assign upd_ent = btb[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
  assign mispredict  = !rst && upd_valid && (upd_pred_pc != redirect_pc);

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat (
    .cnt      (upd_ent.cnt),
    .taken    (upd_taken),
    .cnt_next (upd_cnt_next)
  );

  // Writes land at the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        btb[upd_idx].cnt <= upd_cnt_next;
        if (upd_taken) btb[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        btb[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: WEAK_TAKEN};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookup_q, hit_q, mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_q <= '0;
      hit_q    <= '0;
      mis_q    <= '0;
    end else if (upd_valid) begin
      lookup_q <= lookup_q + 32'd1;
      if (upd_hit)    hit_q <= hit_q + 32'd1;
      if (mispredict) mis_q <= mis_q + 32'd1;
    end
  end

  assign lookup_num     = lookup_q;
  assign hit_num        = hit_q;
  assign mispredict_num = mis_q;
`else
  assign lookup_num     = 32'd0;
  assign hit_num        = 32'd0;
  assign mispredict_num = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, stats/reset sequence, random vs. model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcif;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] lookup_num, hit_num, mispredict_num;

  branch_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcif           (pcif),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_pc    (upd_pred_pc),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .lookup_num     (lookup_num),
    .hit_num        (hit_num),
    .mispredict_num (mispredict_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a 16-slot table of learned branches, kept as plain integers.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  int unsigned m_lookups, m_hits, m_mis;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return !rst && m_hit(pc) && (m_cnt[slot_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_correct_pc();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    return !rst && upd_valid && (upd_pred_pc != m_correct_pc());
  endfunction

  task automatic model_edge();
    int s;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
      end
      m_lookups = 0; m_hits = 0; m_mis = 0;
    end else if (upd_valid) begin
      s = slot_of(upd_pc);
      m_lookups++;
      if (m_mispredict()) m_mis++;
      if (m_hit(upd_pc)) begin
        m_hits++;
        if (upd_taken) begin
          if (m_cnt[s] < 3) m_cnt[s]++;
          m_tgt[s] = upd_target;
        end else if (m_cnt[s] > 0) m_cnt[s]--;
      end else if (upd_taken) begin
        m_valid[s] = 1; m_tag[s] = tag_of(upd_pc); m_tgt[s] = upd_target; m_cnt[s] = 2;
      end
    end
  endtask

  function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef BP_STATS_EN
    return v;
`else
    return (v == v) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    chk({tag, ".lookup_num"},     lookup_num,     exp_stat(m_lookups));
    chk({tag, ".hit_num"},        hit_num,        exp_stat(m_hits));
    chk({tag, ".mispredict_num"}, mispredict_num, exp_stat(m_mis));
  endtask

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pcif;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] upp;
    logic        e_pt;
    logic [31:0] e_npc;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  function automatic vec_t mk(input string name, input logic r, input logic [31:0] pc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic [31:0] upp,
                              input logic e_pt, input logic [31:0] e_npc,
                              input logic e_mis, input logic [31:0] e_red);
    vec_t v;
    v.name = name; v.rst = r; v.pcif = pc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utgt = utgt; v.upp = upp; v.e_pt = e_pt; v.e_npc = e_npc; v.e_mis = e_mis; v.e_red = e_red;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic [31:0] upp);
    rst = r; pcif = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_pc = upp; upd_pred_taken = (upp != upc + 32'd4);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  vec_t vecs [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, rst, pcif, uv, upc, ut, utgt, upp, e_pt, e_npc, e_mis, e_red
    vecs.push_back(mk("reset_lookup",   0, 32'h40, 0, 0, 0, 0, 0,               0, 32'h44,  0, 32'h4));
    vecs.push_back(mk("pc_wrap",        0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0,        0, 32'h0,   0, 32'h4));
    vecs.push_back(mk("alloc",          0, 32'h40, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h44, 1, 32'h100));
    vecs.push_back(mk("alloc_visible",  0, 32'h40, 0, 0, 0, 0, 0,               1, 32'h100, 0, 32'h4));
    vecs.push_back(mk("nt_from2",       0, 32'h40, 1, 32'h40, 0, 32'h0, 32'h100, 1, 32'h100, 1, 32'h44));
    vecs.push_back(mk("cnt1_not_taken", 0, 32'h40, 0, 0, 0, 0, 0,               0, 32'h44,  0, 32'h4));
    vecs.push_back(mk("nt_to0",         0, 32'h40, 1, 32'h40, 0, 32'h0, 32'h44, 0, 32'h44,  0, 32'h44));
    vecs.push_back(mk("nt_sat0",        0, 32'h40, 1, 32'h40, 0, 32'h0, 32'h44, 0, 32'h44,  0, 32'h44));
    vecs.push_back(mk("t_to1",          0, 32'h40, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h44, 1, 32'h100));
    vecs.push_back(mk("t_to2",          0, 32'h40, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h44, 1, 32'h100));
    vecs.push_back(mk("t_to3",          0, 32'h40, 1, 32'h40, 1, 32'h100, 32'h100, 1, 32'h100, 0, 32'h100));
    vecs.push_back(mk("t_sat3",         0, 32'h40, 1, 32'h40, 1, 32'h100, 32'h100, 1, 32'h100, 0, 32'h100));
    vecs.push_back(mk("nt_from3",       0, 32'h40, 1, 32'h40, 0, 32'h0, 32'h100, 1, 32'h100, 1, 32'h44));
    vecs.push_back(mk("still_taken",    0, 32'h40, 0, 0, 0, 0, 0,               1, 32'h100, 0, 32'h4));
    vecs.push_back(mk("alias_miss",     0, 32'h80, 0, 0, 0, 0, 0,               0, 32'h84,  0, 32'h4));
    vecs.push_back(mk("alias_nt",       0, 32'h80, 1, 32'h80, 0, 32'h0, 32'h84, 0, 32'h84,  0, 32'h84));
    vecs.push_back(mk("alias_kept",     0, 32'h40, 0, 0, 0, 0, 0,               1, 32'h100, 0, 32'h4));
    vecs.push_back(mk("alias_replace",  0, 32'h80, 1, 32'h80, 1, 32'h200, 32'h84, 0, 32'h84, 1, 32'h200));
    vecs.push_back(mk("old_tag_miss",   0, 32'h40, 0, 0, 0, 0, 0,               0, 32'h44,  0, 32'h4));
    vecs.push_back(mk("new_tag_hit",    0, 32'h80, 0, 0, 0, 0, 0,               1, 32'h200, 0, 32'h4));
    vecs.push_back(mk("realloc",        0, 32'h40, 1, 32'h40, 1, 32'h100, 32'h44, 0, 32'h44, 1, 32'h100));
    vecs.push_back(mk("read_old",       0, 32'h40, 1, 32'h40, 1, 32'h300, 32'h100, 1, 32'h100, 1, 32'h300));
    vecs.push_back(mk("read_new",       0, 32'h40, 0, 0, 0, 0, 0,               1, 32'h300, 0, 32'h4));
    vecs.push_back(mk("rst_with_upd",   1, 32'h40, 1, 32'h40, 1, 32'h500, 32'h44, 0, 32'h44, 0, 32'h500));
    vecs.push_back(mk("after_rst",      0, 32'h40, 0, 0, 0, 0, 0,               0, 32'h44,  0, 32'h4));

    drive(1, 0, 0, 0, 0, 0, 0);
    finish_cycle();
    finish_cycle();
    drive(0, 32'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_stats("reset");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pcif, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].upp);
      @(negedge clk);
      chk({vecs[i].name, ".pred_taken"},   {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
      chk({vecs[i].name, ".pred_next_pc"}, pred_next_pc,        vecs[i].e_npc);
      chk({vecs[i].name, ".mispredict"},   {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
      chk({vecs[i].name, ".redirect_pc"},  redirect_pc,         vecs[i].e_red);
      finish_cycle();
    end

    // Stats sequence: miss+mispredict, hit+correct, hit+mispredict.
    drive(0, 0, 1, 32'h40, 1, 32'h100, 32'h44);   finish_cycle();
    drive(0, 0, 1, 32'h40, 1, 32'h100, 32'h100);  finish_cycle();
    drive(0, 0, 1, 32'h40, 0, 32'h0,   32'h100);  finish_cycle();
    drive(0, 32'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stats.lookup_num",     lookup_num,     exp_stat(3));
    chk("stats.hit_num",        hit_num,        exp_stat(2));
    chk("stats.mispredict_num", mispredict_num, exp_stat(2));
    chk("stats.pred_taken",     {31'd0, pred_taken}, 32'd1);
    drive(1, 32'h40, 1, 32'h40, 1, 32'h100, 32'h44);
    finish_cycle();
    drive(0, 32'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst.lookup_num",     lookup_num,     32'd0);
    chk("midrst.hit_num",        hit_num,        32'd0);
    chk("midrst.mispredict_num", mispredict_num, 32'd0);
    chk("midrst.pred_next_pc",   pred_next_pc,   32'h44);
    finish_cycle();

    // Random phase against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic        r, uv, ut;
      logic [31:0] pc, upc, tgt, upp;
      r   = ($urandom_range(0, 79) == 0);
      pc  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      uv  = ($urandom_range(0, 9) < 6);
      upc = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 3) == 0) pc = upc;
      ut  = $urandom_range(0, 1) == 1;
      tgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      case ($urandom_range(0, 2))
        0:       upp = upc + 32'd4;
        1:       upp = tgt;
        default: upp = m_pred_pc(upc);
      endcase
      drive(r, pc, uv, upc, ut, tgt, upp);
      @(negedge clk);
      chk("rand.pred_taken",   {31'd0, pred_taken}, {31'd0, m_pred_taken(pc)});
      chk("rand.pred_next_pc", pred_next_pc,        m_pred_pc(pc));
      chk("rand.mispredict",   {31'd0, mispredict}, {31'd0, m_mispredict()});
      chk("rand.redirect_pc",  redirect_pc,         m_correct_pc());
      check_stats("rand");
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
